coremesh_cluster_sram_arb: RTL and testbench

- SRAM front-end of a coremesh cluster; arbitrates N_CORES core-side memory request ports onto one shared byte-enabled synchronous SRAM port.
- The SRAM behind it:
  - writes the enabled byte lanes at the clock edge;
  - returns read data one cycle after the address is presented.
- Sits between the cluster cores and the cluster SRAM macro/model.

---
 rtl/coremesh_cluster_sram_arb_if.sv | 47 ++++
 rtl/coremesh_cluster_sram_arb.sv | 126 ++++++++++++
 tb/tb_coremesh_cluster_sram_arb.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/coremesh_cluster_sram_arb_if.sv
// Core-side request/response and SRAM-side bus of the coremesh cluster SRAM arbiter.
// Optional core_rsp_err exists only when COREMESH_CLUSTER_SRAM_ERR_EN is defined.
interface coremesh_cluster_sram_arb_if #(
  parameter int N_CORES   = 4,
  parameter int ADR_WIDTH = 20,
  parameter int DAT_WIDTH = 32
);
  localparam int BE_WIDTH = DAT_WIDTH / 8;

  logic [N_CORES-1:0]           core_req;
  logic [N_CORES-1:0]           core_gnt;
  logic [N_CORES*ADR_WIDTH-1:0] core_addr;
  logic [N_CORES-1:0]           core_we;
  logic [N_CORES*BE_WIDTH-1:0]  core_byte_en;
  logic [N_CORES*DAT_WIDTH-1:0] core_wdata;
  logic [N_CORES-1:0]           core_rsp_valid;
  logic [DAT_WIDTH-1:0]         core_rdata;
`ifdef COREMESH_CLUSTER_SRAM_ERR_EN
  logic                         core_rsp_err;
`endif

  logic [ADR_WIDTH-1:0]         sram_addr;
  logic                         sram_write_en;
  logic [BE_WIDTH-1:0]          sram_byte_en;
  logic [DAT_WIDTH-1:0]         sram_write_data;
  logic [DAT_WIDTH-1:0]         sram_read_data;

  // Arbiter view
  modport slave (
    input  core_req, core_addr, core_we, core_byte_en, core_wdata, sram_read_data,
    output core_gnt, core_rsp_valid, core_rdata,
           sram_addr, sram_write_en, sram_byte_en, sram_write_data
`ifdef COREMESH_CLUSTER_SRAM_ERR_EN
    , output core_rsp_err
`endif
  );

  // Cores plus SRAM view
  modport master (
    output core_req, core_addr, core_we, core_byte_en, core_wdata, sram_read_data,
    input  core_gnt, core_rsp_valid, core_rdata,
           sram_addr, sram_write_en, sram_byte_en, sram_write_data
`ifdef COREMESH_CLUSTER_SRAM_ERR_EN
    , input core_rsp_err
`endif
  );
endinterface

// File: rtl/coremesh_cluster_sram_arb.sv
// Round-robin arbiter of N_CORES request ports onto one byte-enabled synchronous SRAM port.
// COREMESH_CLUSTER_SRAM_ERR_EN adds out-of-range detection (addr >= MEM_WORDS) with core_rsp_err.
module coremesh_cluster_sram_arb #(
  parameter int              N_CORES   = 4,
  parameter int              ADR_WIDTH = 20,
  parameter int              DAT_WIDTH = 32,
  parameter longint unsigned MEM_WORDS = 64'd1 << ADR_WIDTH
) (
  input  logic                      clock,
  input  logic                      reset,
  coremesh_cluster_sram_arb_if.slave bus
);
  localparam int BE_WIDTH = DAT_WIDTH / 8;
  localparam int PTR_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     next_ptr;
  logic [PTR_W-1:0]     gnt_idx;
  logic [PTR_W-1:0]     rsp_idx_q;
  logic [N_CORES-1:0]   gnt;
  logic                 gnt_any;
  logic                 addr_ok;
  logic                 issue;
  logic [ADR_WIDTH-1:0] sel_addr;
  logic                 sel_we;
  logic [BE_WIDTH-1:0]  sel_be;
  logic [DAT_WIDTH-1:0] sel_wdata;
  logic                 rsp_valid_q;
  logic                 rsp_we_q;
  logic                 rsp_err_q;
  int                   cand;

  // Scan cores starting at rr_ptr with wrap; first requester wins. No grants during reset.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = 0;
    if (!reset) begin
      for (int k = 0; k < N_CORES; k++) begin
        cand = int'(rr_ptr) + k;
        if (cand >= N_CORES) cand = cand - N_CORES;
        for (int i = 0; i < N_CORES; i++) begin
          if (!gnt_any && (cand == i) && bus.core_req[i]) begin
            gnt_any = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = PTR_W'(i);
          end
        end
      end
    end
  end

  assign bus.core_gnt = gnt;

  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int i = 0; i < N_CORES; i++) begin
      if (gnt[i]) begin
        sel_addr  = bus.core_addr[i*ADR_WIDTH +: ADR_WIDTH];
        sel_we    = bus.core_we[i];
        sel_be    = bus.core_byte_en[i*BE_WIDTH +: BE_WIDTH];
        sel_wdata = bus.core_wdata[i*DAT_WIDTH +: DAT_WIDTH];
      end
    end
  end

`ifdef COREMESH_CLUSTER_SRAM_ERR_EN
  assign addr_ok = 64'(sel_addr) < MEM_WORDS;
`else
  assign addr_ok = 1'b1;
`endif

  // Out-of-range requests are still granted but leave the SRAM port idle.
  assign issue = gnt_any & addr_ok;

  always_comb begin
    bus.sram_addr       = '0;
    bus.sram_write_en   = 1'b0;
    bus.sram_byte_en    = '0;
    bus.sram_write_data = '0;
    if (issue) begin
      bus.sram_addr       = sel_addr;
      bus.sram_write_en   = sel_we;
      bus.sram_byte_en    = sel_we ? sel_be : '1;
      bus.sram_write_data = sel_wdata;
    end
  end

  assign next_ptr = (gnt_idx == PTR_W'(N_CORES - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_idx_q   <= '0;
      rsp_we_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= gnt_any;
      if (gnt_any) begin
        rr_ptr    <= next_ptr;
        rsp_idx_q <= gnt_idx;
        rsp_we_q  <= sel_we;
        rsp_err_q <= ~addr_ok;
      end
    end
  end

  always_comb begin
    bus.core_rsp_valid = '0;
    for (int i = 0; i < N_CORES; i++) begin
      bus.core_rsp_valid[i] = rsp_valid_q && (rsp_idx_q == PTR_W'(i));
    end
  end

  // Writes and errored accesses return zero data.
  assign bus.core_rdata = (rsp_valid_q && !rsp_we_q && !rsp_err_q) ? bus.sram_read_data : '0;

`ifdef COREMESH_CLUSTER_SRAM_ERR_EN
  assign bus.core_rsp_err = rsp_valid_q & rsp_err_q;
`endif
endmodule

// File: tb/tb_coremesh_cluster_sram_arb.sv
// Directed table-driven bench for coremesh_cluster_sram_arb with a behavioural byte-lane SRAM.
// Builds with or without COREMESH_CLUSTER_SRAM_ERR_EN (error case uses MEM_WORDS=1024).
module tb_coremesh_cluster_sram_arb;
  localparam int N  = 4;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int BW = DW / 8;
`ifdef COREMESH_CLUSTER_SRAM_ERR_EN
  localparam longint unsigned MW = 1024;
`else
  localparam longint unsigned MW = 64'd1 << AW;
`endif

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  coremesh_cluster_sram_arb_if #(.N_CORES(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW)) bus ();

  coremesh_cluster_sram_arb #(
    .N_CORES(N), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .MEM_WORDS(MW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // SRAM model: port values captured at negedge, written/read at the following posedge.
  logic [DW-1:0] mem [int];
  logic [AW-1:0] cap_addr;
  logic          cap_we;
  logic [BW-1:0] cap_be;
  logic [DW-1:0] cap_wd;
  logic [DW-1:0] word;

  always @(negedge clock) begin
    cap_addr = bus.sram_addr;
    cap_we   = bus.sram_write_en;
    cap_be   = bus.sram_byte_en;
    cap_wd   = bus.sram_write_data;
  end

  always @(posedge clock) begin
    bus.sram_read_data <= mem.exists(int'(cap_addr)) ? mem[int'(cap_addr)] : '0;
    if (cap_we === 1'b1) begin
      word = mem.exists(int'(cap_addr)) ? mem[int'(cap_addr)] : '0;
      for (int b = 0; b < BW; b++)
        if (cap_be[b]) word[b*8 +: 8] = cap_wd[b*8 +: 8];
      mem[int'(cap_addr)] = word;
    end
  end

  typedef struct {
    logic [N-1:0]  req;
    logic          we;
    logic [AW-1:0] addr;
    logic [BW-1:0] be;
    logic [DW-1:0] wd;
    logic [N-1:0]  e_gnt;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [BW-1:0] e_be;
    logic [DW-1:0] e_wd;
    logic [N-1:0]  e_rv;
    logic [DW-1:0] e_rd;
    logic          e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Requesting cores get the row fields; idle cores carry junk that must never reach the SRAM.
  task automatic apply(input vec_t v);
    for (int i = 0; i < N; i++) begin
      if (v.req[i]) begin
        bus.core_we[i]                = v.we;
        bus.core_addr[i*AW +: AW]     = v.addr;
        bus.core_byte_en[i*BW +: BW]  = v.be;
        bus.core_wdata[i*DW +: DW]    = v.wd;
      end else begin
        bus.core_we[i]                = 1'b1;
        bus.core_addr[i*AW +: AW]     = 20'hFFFFF;
        bus.core_byte_en[i*BW +: BW]  = 4'hA;
        bus.core_wdata[i*DW +: DW]    = 32'hBAD0_0000 | DW'(i);
      end
    end
    bus.core_req = v.req;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    apply(v);
    @(negedge clock);
    chk({tag, ".gnt"},       64'(bus.core_gnt),        64'(v.e_gnt));
    chk({tag, ".sram_we"},   64'(bus.sram_write_en),   64'(v.e_we));
    chk({tag, ".sram_addr"}, 64'(bus.sram_addr),       64'(v.e_addr));
    chk({tag, ".sram_be"},   64'(bus.sram_byte_en),    64'(v.e_be));
    chk({tag, ".sram_wd"},   64'(bus.sram_write_data), 64'(v.e_wd));
    chk({tag, ".rsp_valid"}, 64'(bus.core_rsp_valid),  64'(v.e_rv));
    chk({tag, ".rdata"},     64'(bus.core_rdata),      64'(v.e_rd));
`ifdef COREMESH_CLUSTER_SRAM_ERR_EN
    chk({tag, ".rsp_err"},   64'(bus.core_rsp_err),    64'(v.e_err));
`endif
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    checks = 0;
    errors = 0;

    //            req     we    addr       be     wd              e_gnt   e_we  e_addr     e_be   e_wd            e_rv    e_rd           e_err
    vecs.push_back('{4'b0001, 1'b1, 20'h00010, 4'hF, 32'hDEADBEEF, 4'b0001, 1'b1, 20'h00010, 4'hF, 32'hDEADBEEF, 4'b0000, 32'h0,        1'b0});
    vecs.push_back('{4'b0010, 1'b0, 20'h00010, 4'h0, 32'h0,        4'b0010, 1'b0, 20'h00010, 4'hF, 32'h0,        4'b0001, 32'h0,        1'b0});
    vecs.push_back('{4'b0001, 1'b1, 20'h00010, 4'h3, 32'h11223344, 4'b0001, 1'b1, 20'h00010, 4'h3, 32'h11223344, 4'b0010, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{4'b0100, 1'b0, 20'h00010, 4'h0, 32'h0,        4'b0100, 1'b0, 20'h00010, 4'hF, 32'h0,        4'b0001, 32'h0,        1'b0});
    vecs.push_back('{4'b0000, 1'b0, 20'h0,     4'h0, 32'h0,        4'b0000, 1'b0, 20'h0,     4'h0, 32'h0,        4'b0100, 32'hDEAD3344, 1'b0});
    vecs.push_back('{4'b1000, 1'b1, 20'h00020, 4'hF, 32'hCAFEF00D, 4'b1000, 1'b1, 20'h00020, 4'hF, 32'hCAFEF00D, 4'b0000, 32'h0,        1'b0});
    vecs.push_back('{4'b1111, 1'b0, 20'h00020, 4'h0, 32'h0,        4'b0001, 1'b0, 20'h00020, 4'hF, 32'h0,        4'b1000, 32'h0,        1'b0});
    vecs.push_back('{4'b1111, 1'b0, 20'h00020, 4'h0, 32'h0,        4'b0010, 1'b0, 20'h00020, 4'hF, 32'h0,        4'b0001, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 20'h00020, 4'h0, 32'h0,        4'b0100, 1'b0, 20'h00020, 4'hF, 32'h0,        4'b0010, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 20'h00020, 4'h0, 32'h0,        4'b1000, 1'b0, 20'h00020, 4'hF, 32'h0,        4'b0100, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{4'b1111, 1'b0, 20'h00020, 4'h0, 32'h0,        4'b0001, 1'b0, 20'h00020, 4'hF, 32'h0,        4'b1000, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{4'b0000, 1'b0, 20'h0,     4'h0, 32'h0,        4'b0000, 1'b0, 20'h0,     4'h0, 32'h0,        4'b0001, 32'hCAFEF00D, 1'b0});
    vecs.push_back('{4'b0101, 1'b0, 20'h00010, 4'h0, 32'h0,        4'b0100, 1'b0, 20'h00010, 4'hF, 32'h0,        4'b0000, 32'h0,        1'b0});
    vecs.push_back('{4'b0101, 1'b0, 20'h00010, 4'h0, 32'h0,        4'b0001, 1'b0, 20'h00010, 4'hF, 32'h0,        4'b0100, 32'hDEAD3344, 1'b0});
    vecs.push_back('{4'b0000, 1'b0, 20'h0,     4'h0, 32'h0,        4'b0000, 1'b0, 20'h0,     4'h0, 32'h0,        4'b0001, 32'hDEAD3344, 1'b0});

    // Reset held for 20 cycles with every core trying to write.
    reset = 1'b1;
    v = '{4'b1111, 1'b1, 20'h00010, 4'hF, 32'h55AA55AA, 4'b0, 1'b0, 20'h0, 4'h0, 32'h0, 4'b0, 32'h0, 1'b0};
    apply(v);
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      chk("reset.gnt",       64'(bus.core_gnt),       64'd0);
      chk("reset.rsp_valid", 64'(bus.core_rsp_valid), 64'd0);
      chk("reset.sram_we",   64'(bus.sram_write_en),  64'd0);
      @(posedge clock);
    end
    #1;
    reset = 1'b0;

    for (int r = 0; r < vecs.size(); r++) run_vec(vecs[r], $sformatf("vec%0d", r));

    // Read granted to core2 (rr_ptr=1), then reset: response is dropped and rr_ptr returns to 0.
    v = '{4'b0100, 1'b0, 20'h00010, 4'h0, 32'h0, 4'b0100, 1'b0, 20'h00010, 4'hF, 32'h0, 4'b0000, 32'h0, 1'b0};
    run_vec(v, "rst_mid.grant");
    reset = 1'b1;
    v = '{4'b1111, 1'b0, 20'h00010, 4'h0, 32'h0, 4'b0, 1'b0, 20'h0, 4'h0, 32'h0, 4'b0, 32'h0, 1'b0};
    apply(v);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      chk("rst_mid.rsp_valid", 64'(bus.core_rsp_valid), 64'd0);
      chk("rst_mid.rdata",     64'(bus.core_rdata),     64'd0);
      chk("rst_mid.gnt",       64'(bus.core_gnt),       64'd0);
      @(posedge clock);
    end
    #1;
    reset = 1'b0;
    v = '{4'b1111, 1'b0, 20'h00010, 4'h0, 32'h0, 4'b0001, 1'b0, 20'h00010, 4'hF, 32'h0, 4'b0000, 32'h0, 1'b0};
    run_vec(v, "rst_mid.after");
    v = '{4'b0000, 1'b0, 20'h0, 4'h0, 32'h0, 4'b0000, 1'b0, 20'h0, 4'h0, 32'h0, 4'b0001, 32'hDEAD3344, 1'b0};
    run_vec(v, "rst_mid.rsp");

`ifdef COREMESH_CLUSTER_SRAM_ERR_EN
    // Out-of-range read: granted, SRAM port idle, error response next cycle.
    v = '{4'b0001, 1'b0, 20'h00400, 4'h0, 32'h0, 4'b0001, 1'b0, 20'h0, 4'h0, 32'h0, 4'b0000, 32'h0, 1'b0};
    run_vec(v, "err.grant");
    v = '{4'b0000, 1'b0, 20'h0, 4'h0, 32'h0, 4'b0000, 1'b0, 20'h0, 4'h0, 32'h0, 4'b0001, 32'h0, 1'b1};
    run_vec(v, "err.rsp");
    v = '{4'b0010, 1'b0, 20'h003FF, 4'h0, 32'h0, 4'b0010, 1'b0, 20'h003FF, 4'hF, 32'h0, 4'b0000, 32'h0, 1'b0};
    run_vec(v, "err.edge_ok");
    v = '{4'b0000, 1'b0, 20'h0, 4'h0, 32'h0, 4'b0000, 1'b0, 20'h0, 4'h0, 32'h0, 4'b0010, 32'h0, 1'b0};
    run_vec(v, "err.edge_rsp");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
